// File: rtl/sa_pkg.sv
// Shared constants, FSM state type and small helpers for the systolic-array sequencer.
package sa_pkg;

    localparam int SA_ROWS = 25;
    localparam int SA_COLS = 16;
    localparam int SA_AW   = 6;
    localparam int SA_BW   = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WLOAD     = 3'd1,
        WAIT_DATA = 3'd2,
        STREAM    = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } sa_ctrl_state_t;

    // Saturating increment for the 32-bit stall counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Delay line for accu_valid: tap i is the input delayed i cycles (tap 0 is din itself);
// taps ROWS-1 .. ROWS+COLS-2 are registered once more onto taps_o.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int ROWS = SA_ROWS,
    parameter int COLS = SA_COLS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            din,
    output logic [COLS-1:0] taps_o
);

    localparam int DEPTH = ROWS + COLS - 1;

    // sr_r[k] holds din delayed k+1 cycles, so tap ROWS-1+c lives at index ROWS-2+c.
    logic [DEPTH-2:0] sr_r;
    logic [COLS-1:0]  taps_r;

    // Shift register, clocked in every state so a drain always empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r <= {(DEPTH-1){1'b0}};
        end else begin
            sr_r <= {sr_r[DEPTH-3:0], din};
        end
    end

    // Registered column taps: column c sees the beat ROWS+c cycles after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_r <= {COLS{1'b0}};
        end else begin
            for (int c = 0; c < COLS; c++) begin
                taps_r[c] <= sr_r[ROWS-2+c];
            end
        end
    end

    assign taps_o = taps_r;

endmodule

// File: rtl/sa_ctrl.sv
// Sequencer for the ROWSxCOLS systolic array: weight load, data window, skewed accu_valid, drain.
// Optional build macro SA_CTRL_PERF_EN adds saturating weight/data stall counters.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int ROWS = SA_ROWS,
    parameter int COLS = SA_COLS,
    parameter int AW   = SA_AW,
    parameter int BW   = SA_BW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            nth_conv_i,
    input  logic [BW-1:0]   num_burst_i,
    input  logic            wbuf_valid_i,
    output logic            wbuf_ready_o,
    output logic [COLS-1:0] w_enable_o,
    output logic [AW-1:0]   w_addr_o,
    output logic            data_enable_o,
    input  logic            dvalid_i,
    input  logic            burst_last_i,
    output logic [COLS-1:0] accu_valid_o,
    output logic            busy_o,
    output logic            done_o
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [31:0]     wstall_cnt_o,
    output logic [31:0]     dstall_cnt_o
`endif
);

    localparam int DRAIN_LEN = ROWS + COLS - 1;
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DCW       = $clog2(DRAIN_LEN);

    sa_ctrl_state_t state_r;
    logic [AW-1:0]  row_r;
    logic [CW-1:0]  col_r;
    logic [BW-1:0]  burst_cnt_r;
    logic [BW-1:0]  num_burst_r;
    logic [DCW-1:0] drain_cnt_r;
    logic           wbuf_ready_r;
    logic           data_enable_r;
    logic           busy_r;
    logic           done_r;

    logic           accept_s;
    logic [COLS-1:0] w_enable_s;

    // Only beats inside the data window enter the skew line.
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == WAIT_DATA) || (state_r == STREAM)) begin
            accept_s = dvalid_i;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Column write strobe follows wbuf_valid_i in the same cycle so a stalled beat never writes.
    always_comb begin
        w_enable_s = {COLS{1'b0}};
        if ((state_r == WLOAD) && wbuf_valid_i) begin
            w_enable_s = {{(COLS-1){1'b0}}, 1'b1} << col_r;
        end else begin
            w_enable_s = {COLS{1'b0}};
        end
    end

    // Main sequencer: state, counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            row_r         <= {AW{1'b0}};
            col_r         <= {CW{1'b0}};
            burst_cnt_r   <= {BW{1'b0}};
            num_burst_r   <= {BW{1'b0}};
            drain_cnt_r   <= {DCW{1'b0}};
            wbuf_ready_r  <= 1'b0;
            data_enable_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        num_burst_r <= (num_burst_i == {BW{1'b0}}) ? BW'(1) : num_burst_i;
                        burst_cnt_r <= {BW{1'b0}};
                        row_r       <= {AW{1'b0}};
                        col_r       <= {CW{1'b0}};
                        busy_r      <= 1'b1;
                        if (!nth_conv_i) begin
                            state_r      <= WLOAD;
                            wbuf_ready_r <= 1'b1;
                        end else begin
                            state_r       <= WAIT_DATA;
                            data_enable_r <= 1'b1;
                        end
                    end
                end
                WLOAD: begin
                    if (wbuf_valid_i) begin
                        if (row_r == AW'(ROWS-1)) begin
                            row_r <= {AW{1'b0}};
                            if (col_r == CW'(COLS-1)) begin
                                col_r         <= {CW{1'b0}};
                                state_r       <= WAIT_DATA;
                                wbuf_ready_r  <= 1'b0;
                                data_enable_r <= 1'b1;
                            end else begin
                                col_r <= col_r + CW'(1);
                            end
                        end else begin
                            row_r <= row_r + AW'(1);
                        end
                    end
                end
                WAIT_DATA, STREAM: begin
                    if (dvalid_i) begin
                        if (burst_last_i) begin
                            burst_cnt_r <= burst_cnt_r + BW'(1);
                            if ((burst_cnt_r + BW'(1)) == num_burst_r) begin
                                state_r       <= DRAIN;
                                data_enable_r <= 1'b0;
                                drain_cnt_r   <= {DCW{1'b0}};
                            end else begin
                                state_r <= STREAM;
                            end
                        end else begin
                            state_r <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == DCW'(DRAIN_LEN-1)) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DCW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r       <= IDLE;
                    wbuf_ready_r  <= 1'b0;
                    data_enable_r <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    sa_skew_line #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_skew (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (accept_s),
        .taps_o (accu_valid_o)
    );

`ifdef SA_CTRL_PERF_EN
    logic [31:0] wstall_r;
    logic [31:0] dstall_r;

    // Stall counters, cleared by an accepted start and saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstall_r <= 32'd0;
            dstall_r <= 32'd0;
        end else if ((state_r == IDLE) && start) begin
            wstall_r <= 32'd0;
            dstall_r <= 32'd0;
        end else begin
            if ((state_r == WLOAD) && !wbuf_valid_i) begin
                wstall_r <= sat_inc32(wstall_r);
            end
            if ((state_r == STREAM) && !dvalid_i) begin
                dstall_r <= sat_inc32(dstall_r);
            end
        end
    end

    assign wstall_cnt_o = wstall_r;
    assign dstall_cnt_o = dstall_r;
`endif

    assign wbuf_ready_o  = wbuf_ready_r;
    assign w_enable_o    = w_enable_s;
    assign w_addr_o      = row_r;
    assign data_enable_o = data_enable_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;

endmodule

// File: tb/tb_sa_ctrl.sv
// Self-checking bench for sa_ctrl: table of convolution passes plus a mid-load reset sequence.
module tb_sa_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        nth_conv_i = 1'b0;
    logic [7:0]  num_burst_i = 8'd0;
    logic        wbuf_valid_i = 1'b0;
    logic        dvalid_i = 1'b0;
    logic        burst_last_i = 1'b0;
    logic        wbuf_ready_o;
    logic [15:0] w_enable_o;
    logic [5:0]  w_addr_o;
    logic        data_enable_o;
    logic [15:0] accu_valid_o;
    logic        busy_o;
    logic        done_o;
`ifdef SA_CTRL_PERF_EN
    logic [31:0] wstall_cnt_o;
    logic [31:0] dstall_cnt_o;
`endif

    sa_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .nth_conv_i    (nth_conv_i),
        .num_burst_i   (num_burst_i),
        .wbuf_valid_i  (wbuf_valid_i),
        .wbuf_ready_o  (wbuf_ready_o),
        .w_enable_o    (w_enable_o),
        .w_addr_o      (w_addr_o),
        .data_enable_o (data_enable_o),
        .dvalid_i      (dvalid_i),
        .burst_last_i  (burst_last_i),
        .accu_valid_o  (accu_valid_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
`ifdef SA_CTRL_PERF_EN
        ,
        .wstall_cnt_o  (wstall_cnt_o),
        .dstall_cnt_o  (dstall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         nth;
        logic [7:0] nb;
        int         nbursts;
        int         blen;
        int         gap;
        bit         wtoggle;
        bit         start_mid;
        int         exp_wcyc;
        int         exp_lat;
        int         exp_beats;
        int         exp_wstall;
        int         exp_dstall;
    } vec_t;

    vec_t tbl [6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit exp_accept = 1'b0;
    bit hist [8192];
    int av0_cnt = 0;
    int av15_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected accu_valid: column c echoes the beat accepted 25+c cycles earlier.
    function automatic logic [15:0] exp_av(input int n);
        logic [15:0] e;
        e = 16'd0;
        for (int c = 0; c < 16; c++) begin
            if ((n - 25 - c) >= 0) begin
                e[c] = hist[n-25-c];
            end
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && (cyc < 8192)) begin
            check("accu_valid", 32'(accu_valid_o), 32'(exp_av(cyc)));
            hist[cyc] <= exp_accept;
            if (accu_valid_o[0])  av0_cnt  <= av0_cnt + 1;
            if (accu_valid_o[15]) av15_cnt <= av15_cnt + 1;
        end
    end

    task automatic run_pass(input vec_t v);
        int wcyc, writes, row, col, lat, b0, b15;
        bit wv;
        b0  = av0_cnt;
        b15 = av15_cnt;
        @(posedge clk); #1;
        start = 1'b1; nth_conv_i = v.nth; num_burst_i = v.nb;
        @(posedge clk); #1;
        // Scramble sampled inputs so a re-sample would be visible.
        start = 1'b0; nth_conv_i = ~v.nth; num_burst_i = 8'hA5;
        if (!v.nth) begin
            wcyc = 0; writes = 0; row = 0; col = 0;
            while ((writes < 400) && (wcyc < 2000)) begin
                // Toggling source: low on even cycles, high on odd ones.
                wv = v.wtoggle ? (wcyc % 2 == 1) : 1'b1;
                wbuf_valid_i = wv;
                @(negedge clk);
                check("wbuf_ready", 32'(wbuf_ready_o), 32'd1);
                check("w_addr", 32'(w_addr_o), row);
                check("w_enable", 32'(w_enable_o), wv ? (32'd1 << col) : 32'd0);
                check("data_enable_in_wload", 32'(data_enable_o), 32'd0);
                if (wv) begin
                    writes++;
                    if (row == 24) begin
                        row = 0;
                        col++;
                    end else begin
                        row++;
                    end
                end
                wcyc++;
                @(posedge clk); #1;
            end
            wbuf_valid_i = 1'b0;
            check("wload_cycles", wcyc, v.exp_wcyc);
        end
        for (int b = 0; b < v.nbursts; b++) begin
            if (b > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    dvalid_i = 1'b0; burst_last_i = 1'b0; exp_accept = 1'b0;
                    @(negedge clk);
                    check("data_enable_gap", 32'(data_enable_o), 32'd1);
                    @(posedge clk); #1;
                end
            end
            for (int k = 0; k < v.blen; k++) begin
                dvalid_i = 1'b1;
                burst_last_i = (k == v.blen - 1);
                exp_accept = 1'b1;
                start = v.start_mid && (b == 0) && (k == 2);
                @(negedge clk);
                check("data_enable_beat", 32'(data_enable_o), 32'd1);
                check("w_enable_in_data", 32'(w_enable_o), 32'd0);
                check("busy_in_data", 32'(busy_o), 32'd1);
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        // Beats during the drain must be ignored.
        dvalid_i = 1'b1; burst_last_i = 1'b1; exp_accept = 1'b0;
        lat = 1;
        @(negedge clk);
        check("data_enable_fall", 32'(data_enable_o), 32'd0);
        while (lat < 200) begin
            if (done_o === 1'b1) break;
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
        end
        check("done_latency", lat, v.exp_lat);
        @(posedge clk); #1;
        dvalid_i = 1'b0; burst_last_i = 1'b0;
        @(negedge clk);
        check("done_width", 32'(done_o), 32'd0);
        check("busy_after_done", 32'(busy_o), 32'd0);
        check("accu0_pulses", av0_cnt - b0, v.exp_beats);
        check("accu15_pulses", av15_cnt - b15, v.exp_beats);
`ifdef SA_CTRL_PERF_EN
        check("wstall_cnt", wstall_cnt_o, v.exp_wstall);
        check("dstall_cnt", dstall_cnt_o, v.exp_dstall);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w_enable"}, 32'(w_enable_o), 32'd0);
        check({tag, "_wbuf_ready"}, 32'(wbuf_ready_o), 32'd0);
        check({tag, "_w_addr"}, 32'(w_addr_o), 32'd0);
        check({tag, "_data_enable"}, 32'(data_enable_o), 32'd0);
        check({tag, "_accu_valid"}, 32'(accu_valid_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        //          nth   nb     nbu blen gap wtog  smid  wcyc lat beats wstall dstall
        tbl[0] = '{1'b0, 8'd1,  1,  30,  0, 1'b0, 1'b0, 400, 41, 30,   0,     0};
        tbl[1] = '{1'b0, 8'd1,  1,  30,  0, 1'b1, 1'b0, 800, 41, 30,   400,   0};
        tbl[2] = '{1'b1, 8'd1,  1,  30,  0, 1'b0, 1'b0, 0,   41, 30,   0,     0};
        tbl[3] = '{1'b1, 8'd3,  3,  30,  5, 1'b0, 1'b0, 0,   41, 90,   0,     10};
        tbl[4] = '{1'b1, 8'd0,  1,  30,  0, 1'b0, 1'b1, 0,   41, 30,   0,     0};
        tbl[5] = '{1'b1, 8'd2,  2,  1,   3, 1'b0, 1'b0, 0,   41, 2,    0,     3};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                // Beats in IDLE must not reach the skew line.
                dvalid_i = 1'b1; burst_last_i = 1'b1; exp_accept = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                dvalid_i = 1'b0; burst_last_i = 1'b0;
                @(negedge clk);
                check("idle_ignores_dvalid", 32'(busy_o), 32'd0);
            end
            run_pass(tbl[i]);
        end

        // Reset in the middle of a weight load at column 7.
        @(posedge clk); #1;
        start = 1'b1; nth_conv_i = 1'b0; num_burst_i = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wbuf_valid_i = 1'b1;
        repeat (178) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_load_w_enable", 32'(w_enable_o), 32'h0000_0080);
        check("mid_load_w_addr", 32'(w_addr_o), 32'd3);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        wbuf_valid_i = 1'b0;
        @(posedge clk); #1;
        check("abort_no_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        run_pass(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_ctrl.md
Name: sa_ctrl

Overview:
Sequencer for the 25x16 systolic array (SA_TOP).
- On start, it loads weights column by column from a weight buffer (skipped for reuse convolutions).
- It then opens the data window and counts input bursts.
- It generates per-column skewed accu_valid strobes and drains the array pipeline before signalling done.
- It sits between the layer controller / DMA and SA_TOP.

Parameters:
ROWS, 25, array rows = weights per column = data lanes
COLS, 16, array columns
AW, 6, weight address width (must satisfy 2^AW >= ROWS)
BW, 8, burst-count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run one convolution pass
nth_conv_i  in  1  1 = weights already resident, skip weight load
num_burst_i  in  BW  bursts in this pass, sampled with start; value 0 is treated as 1
wbuf_valid_i  in  1  weight source has a beat on w_data this cycle
wbuf_ready_o  out  1  controller consumes weight beat (high in WLOAD)
w_enable_o  out  COLS  one-hot column write strobe to SA_TOP w_enable
w_addr_o  out  AW  row address for the weight write, shared by all columns
data_enable_o  out  1  data window open; feeder may send bursts
dvalid_i  in  1  data beat valid on SA_TOP data_i
burst_last_i  in  1  last beat of current burst, qualified by dvalid_i
accu_valid_o  out  COLS  column c = accepted-beat strobe delayed ROWS+c cycles
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, skew line cleared.
- States and transitions:
  - IDLE: start samples num_burst_i and nth_conv_i. Next state is WLOAD if nth_conv_i=0, else WAIT_DATA. start in any other state is ignored.
  - WLOAD: wbuf_ready_o=1.
    - w_enable_o[col]=wbuf_valid_i (combinational); w_addr_o=row.
    - Each beat with wbuf_valid_i=1 increments row. At ROWS-1, row wraps to 0 and col increments.
    - Beat at (col=COLS-1, row=ROWS-1) moves to WAIT_DATA.
    - wbuf_valid_i=0 stalls; counters hold and w_enable_o=0.
  - WAIT_DATA and STREAM: data_enable_o=1 (registered).
    - First dvalid_i moves WAIT_DATA to STREAM.
    - dvalid_i & burst_last_i increments burst_cnt.
    - When burst_cnt reaches num_burst, go to DRAIN; data_enable_o drops the next cycle.
  - DRAIN: counts ROWS+COLS-1 cycles (40 by default); data_enable_o=0. Then DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- dvalid_i outside WAIT_DATA/STREAM is ignored (not entered into the skew line). burst_last_i without dvalid_i is ignored.
- Skew line: shift register of depth ROWS+COLS-1 fed by the accepted dvalid_i. accu_valid_o[c] is tap ROWS-1+c as a registered output, giving exactly ROWS+c cycles of latency.
- The skew line keeps shifting in every state, so DRAIN always empties it.
- Reset mid-operation aborts immediately to IDLE; no done_o is produced.

Optional Feature:
SA_CTRL_PERF_EN
- Defined: adds outputs wstall_cnt_o[31:0] and dstall_cnt_o[31:0].
  - wstall_cnt_o counts WLOAD cycles with wbuf_valid_i=0.
  - dstall_cnt_o counts STREAM cycles with dvalid_i=0.
  - Both clear on an accepted start and saturate at all-ones.
- Undefined: the ports and counters do not exist.

Decomposition:
- Package sa_pkg: SA_ROWS=25, SA_COLS=16, SA_AW=6 constants; state enum sa_ctrl_state_t {IDLE, WLOAD, WAIT_DATA, STREAM, DRAIN, DONE}.
- One sub-module, sa_skew_line: parameterised shift register of depth ROWS+COLS-1 with COLS taps starting at ROWS-1.

Test Plan:
1. nth_conv_i=0, num_burst_i=1, wbuf_valid_i held 1 -> w_enable_o[0] high 25 cycles with w_addr_o 0..24, then [1]..[15]. 400 write cycles total; data_enable_o rises the cycle after the last write.
2. Same run, wbuf_valid_i toggling 1010 -> 800 WLOAD cycles; w_addr_o/col advance only on valid beats; no w_enable_o pulse when valid is low.
3. nth_conv_i=1, one 30-beat burst, burst_last on beat 30 -> no w_enable_o. accu_valid_o[c] is high 30 consecutive cycles starting 25+c cycles after the first beat. done_o pulses 41 cycles after the burst_last beat.
4. num_burst_i=3, three 30-beat bursts with 5-cycle gaps -> data_enable_o stays high until the third burst_last; dstall_cnt_o=10 under SA_CTRL_PERF_EN.
5. num_burst_i=0 -> behaves as 1. start asserted during STREAM -> ignored; burst_cnt and state unaffected.
6. rst_n low at WLOAD col=7 -> all outputs 0 immediately. A new start afterwards begins at col=0, row=0.
